// File: rtl/aes_128_pkg.sv
// Shared definitions for the aes_128 stream loader: word/block geometry and
// the loader FSM state encoding.
package aes_128_pkg;

  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int WORD_CNT = 4;

  typedef enum logic [1:0] {
    LOAD_TEXT = 2'd0,
    LOAD_KEY  = 2'd1,
    ISSUE     = 2'd2
  } loader_state_t;

endpackage

// File: rtl/aes_128_loader.sv
// Assembles 32-bit stream words into a 128-bit plaintext block and key for the
// aes_128 core, with an optional short frame that reuses the previous key.
module aes_128_loader
  import aes_128_pkg::*;
#(
  parameter logic KEY_REUSE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  input  logic                 s_keep_key,
  output logic                 s_ready,
  output logic [BLOCK_W-1:0]   m_in_bus,
  output logic [BLOCK_W-1:0]   m_key,
  output logic                 m_start,
  input  logic                 m_ready,
  output logic                 key_loaded
);

  localparam logic [1:0] LAST_WORD = 2'(WORD_CNT - 1);

  loader_state_t state;
  logic [1:0]    word_cnt;
  logic          keep_flag;

  // Ready is gated by reset directly so no word is taken while rst is high.
  assign s_ready = (state != ISSUE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_TEXT;
      word_cnt   <= 2'd0;
      keep_flag  <= 1'b0;
      key_loaded <= 1'b0;
      m_start    <= 1'b0;
      m_in_bus   <= '0;
      m_key      <= '0;
    end else begin
      case (state)
        LOAD_TEXT: begin
          if (s_valid) begin
            m_in_bus[BLOCK_W-1-WORD_W*int'(word_cnt) -: WORD_W] <= s_data;
            if (word_cnt == 2'd0) begin
              keep_flag <= s_keep_key;
            end
            if (word_cnt == LAST_WORD) begin
              word_cnt <= 2'd0;
              // The keep request is honoured only once a real key exists.
              if (KEY_REUSE_EN && keep_flag && key_loaded) begin
                state   <= ISSUE;
                m_start <= 1'b1;
              end else begin
                state <= LOAD_KEY;
              end
            end else begin
              word_cnt <= word_cnt + 2'd1;
            end
          end
        end

        LOAD_KEY: begin
          if (s_valid) begin
            m_key[BLOCK_W-1-WORD_W*int'(word_cnt) -: WORD_W] <= s_data;
            if (word_cnt == LAST_WORD) begin
              word_cnt   <= 2'd0;
              state      <= ISSUE;
              m_start    <= 1'b1;
              key_loaded <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 2'd1;
            end
          end
        end

        ISSUE: begin
          if (m_ready) begin
            state    <= LOAD_TEXT;
            m_start  <= 1'b0;
            word_cnt <= 2'd0;
          end
        end

        default: begin
          state    <= LOAD_TEXT;
          m_start  <= 1'b0;
          word_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule
